uart_tx_frame: RTL and testbench

Parametrised UART transmitter: serialises parallel words onto a single TX line with configurable data width, stop-bit count and optional parity. A one-word holding register lets back-to-back frames go out with no idle gap. Sits between the upstream byte producer (valid/ready handshake) and the board TX pin; it is the general-purpose replacement for the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_frame_if.sv | 15 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_frame.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, legal frame-format ranges and bit-period helper.
package uart_pkg;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;
  localparam int unsigned BIT_CNT_W     = $clog2(DATA_BITS_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // System clocks per serial bit.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_mhz,
                                                 input int unsigned baud);
    return (clk_mhz * 32'd1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Upstream word handshake plus TX line and status for uart_tx_frame.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;
  logic                 tx_pin;
  logic                 tx_busy;

  modport master (output tx_data, tx_data_valid,
                  input  tx_data_ready, tx_pin, tx_busy);
  modport slave  (input  tx_data, tx_data_valid,
                  output tx_data_ready, tx_pin, tx_busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; start clears it, bit_done marks the last clock of each bit.
module uart_bit_timer #(
  parameter int unsigned CYCLE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic bit_done
);
  localparam int unsigned CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  if (CYCLE < 2) begin : g_bad_cycle
    $error("uart_bit_timer: CYCLE must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;

  // bit_done is registered one clock early so it is high exactly while cnt_q == CYCLE-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bit_done <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      bit_done <= 1'b0;
    end else begin
      cnt_q    <= (cnt_q == CNT_W'(CYCLE - 1)) ? '0 : cnt_q + CNT_W'(1);
      bit_done <= (cnt_q == CNT_W'(CYCLE - 2));
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits,
// with a one-word holding register. Parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 100,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic            clk,
  input logic            rst,
  uart_tx_frame_if.slave bus
);
  localparam int unsigned CYCLE = cycles_per_bit(CLK_FRE, BAUD_RATE);

  if (CYCLE < 2) begin : g_bad_cycle
    $error("uart_tx_frame: CLK_FRE/BAUD_RATE gives fewer than 2 clocks per bit");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS out of range");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] load_word_c;
  logic                 hold_full_q, hold_full_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 tx_pin_d, tx_busy_d, tx_ready_d;
  logic                 bit_done, timer_start_c;
  logic                 accept_c, last_stop_c, load_c;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_bit_timer #(.CYCLE(CYCLE)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start_c),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    bit_cnt_d     = bit_cnt_q;
    tx_pin_d      = bus.tx_pin;
    timer_start_c = 1'b0;
    load_c        = 1'b0;
    load_word_c   = hold_q;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif
    accept_c    = bus.tx_data_valid && bus.tx_data_ready;
    last_stop_c = (state_q == STOP) && bit_done &&
                  (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1));

    case (state_q)
      START: if (bit_done) begin
        state_d   = DATA;
        tx_pin_d  = shift_q[0];
        bit_cnt_d = '0;
      end
      DATA: if (bit_done) begin
        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = PARITY;
          tx_pin_d  = parity_q;
`else
          state_d   = STOP;
          tx_pin_d  = 1'b1;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          tx_pin_d  = shift_q[1];
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        state_d   = STOP;
        tx_pin_d  = 1'b1;
        bit_cnt_d = '0;
      end
`endif
      STOP: if (bit_done) begin
        if (last_stop_c) begin
          state_d  = IDLE;
          tx_pin_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
      default: ;
    endcase

    // A held word always goes first; a fresh word bypasses the holding register when it is free.
    if (state_q == IDLE || last_stop_c) begin
      if (hold_full_q) begin
        load_c      = 1'b1;
        load_word_c = hold_q;
        hold_full_d = 1'b0;
      end else if (accept_c) begin
        load_c      = 1'b1;
        load_word_c = bus.tx_data;
      end
    end else if (accept_c) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (load_c) begin
      state_d       = START;
      shift_d       = load_word_c;
      tx_pin_d      = 1'b0;
      bit_cnt_d     = '0;
      timer_start_c = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d      = (^load_word_c) ^ PARITY_ODD[0];
`endif
    end

    tx_busy_d  = (state_d != IDLE) || hold_full_d;
    tx_ready_d = !hold_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      shift_q           <= '0;
      hold_q            <= '0;
      hold_full_q       <= 1'b0;
      bit_cnt_q         <= '0;
      bus.tx_pin        <= 1'b1;
      bus.tx_busy       <= 1'b0;
      bus.tx_data_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q          <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      shift_q           <= shift_d;
      hold_q            <= hold_d;
      hold_full_q       <= hold_full_d;
      bit_cnt_q         <= bit_cnt_d;
      bus.tx_pin        <= tx_pin_d;
      bus.tx_busy       <= tx_busy_d;
      bus.tx_data_ready <= tx_ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q          <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: an 8-data/1-stop instance and a 7-data/2-stop odd-parity instance.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int unsigned CLK_FRE = 100;
  localparam int unsigned BAUD    = 10_000_000;
  localparam int unsigned CYCLE   = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBIT = 1;
`else
  localparam int unsigned PBIT = 0;
`endif
  localparam int unsigned DB_A = 8, SB_A = 1, PO_A = 0;
  localparam int unsigned DB_B = 7, SB_B = 2, PO_B = 1;
  localparam int unsigned FRAME_A = (1 + DB_A + PBIT + SB_A) * CYCLE;
  localparam int unsigned FRAME_B = (1 + DB_B + PBIT + SB_B) * CYCLE;
  localparam int unsigned TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame_if #(.DATA_BITS(DB_A)) bus_a ();
  uart_tx_frame_if #(.DATA_BITS(DB_B)) bus_b ();

  uart_tx_frame #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(DB_A),
                  .STOP_BITS(SB_A), .PARITY_ODD(PO_A))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  uart_tx_frame #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .DATA_BITS(DB_B),
                  .STOP_BITS(SB_B), .PARITY_ODD(PO_B))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [8:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  int         start_q_a[$];

  // Expected line level per bit slot: start, data LSB first, optional parity, stop ones.
  function automatic logic [12:0] frame_wave(input logic [8:0] w, input int unsigned db,
                                             input int unsigned po);
    logic [12:0] v;
    logic        p;
    v    = '1;
    v[0] = 1'b0;
    p    = po[0];
    for (int i = 0; i < int'(db); i++) begin
      v[i+1] = w[i];
      p      = p ^ w[i];
    end
`ifdef UART_TX_PARITY_EN
    v[db+1] = p;
`endif
    return v;
  endfunction

  bit          m_in[2];
  int          m_clk[2];
  int          m_errs[2];
  logic [8:0]  m_dec[2];
  logic [8:0]  m_exp[2];
  logic [12:0] m_wave[2];
  int          frames[2];

  // Line monitor: finds a start bit, checks every clock of the frame and decodes mid-bit.
  task automatic mon_step(input int d, input logic pin, input int unsigned db,
                          input int unsigned po, input int unsigned flen);
    int b;
    int qs;
    if (rst) begin
      m_in[d] = 1'b0;
      return;
    end
    if (!m_in[d]) begin
      if (pin !== 1'b0) return;
      m_in[d]   = 1'b1;
      m_clk[d]  = 0;
      m_errs[d] = 0;
      m_dec[d]  = '0;
      frames[d]++;
      if (d == 0) start_q_a.push_back(cyc);
      qs = (d == 0) ? exp_q_a.size() : exp_q_b.size();
      check($sformatf("frame_expected_%0d", d), 32'(qs != 0), 1);
      if (qs == 0) m_exp[d] = '0;
      else if (d == 0) m_exp[d] = exp_q_a.pop_front();
      else m_exp[d] = exp_q_b.pop_front();
      m_wave[d] = frame_wave(m_exp[d], db, po);
    end
    b = m_clk[d] / CYCLE;
    if (pin !== m_wave[d][b]) m_errs[d]++;
    if ((m_clk[d] % CYCLE) == CYCLE / 2 && b >= 1 && b <= int'(db)) m_dec[d][b-1] = pin;
    if (m_clk[d] == int'(flen) - 1) begin
      check($sformatf("frame_data_%0d", d), m_dec[d], m_exp[d]);
      check($sformatf("frame_wave_errs_%0d", d), m_errs[d], 0);
      m_in[d] = 1'b0;
    end else begin
      m_clk[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus_a.tx_pin, DB_A, PO_A, FRAME_A);
    mon_step(1, bus_b.tx_pin, DB_B, PO_B, FRAME_B);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive(input int d, input logic [8:0] w, input bit keep_valid);
    int   n = 0;
    logic rdy;
    if (d == 0) begin
      bus_a.tx_data = w[7:0]; bus_a.tx_data_valid = 1'b1;
    end else begin
      bus_b.tx_data = w[6:0]; bus_b.tx_data_valid = 1'b1;
    end
    rdy = (d == 0) ? bus_a.tx_data_ready : bus_b.tx_data_ready;
    while (rdy !== 1'b1 && n < int'(TIMEOUT)) begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? bus_a.tx_data_ready : bus_b.tx_data_ready;
    end
    if (n >= int'(TIMEOUT)) check($sformatf("accept_timeout_%0d", d), n, 0);
    if (d == 0) exp_q_a.push_back(w & 9'h0FF);
    else        exp_q_b.push_back(w & 9'h07F);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) begin
      if (d == 0) begin
        bus_a.tx_data_valid = 1'b0; bus_a.tx_data = 8'($urandom);
      end else begin
        bus_b.tx_data_valid = 1'b0; bus_b.tx_data = 7'($urandom);
      end
    end
  endtask

  // Counts tx_busy clocks from the current negedge until it drops.
  task automatic wait_idle(input int d, input int limit, output int busy_clks);
    logic bsy;
    busy_clks = 0;
    bsy = (d == 0) ? bus_a.tx_busy : bus_b.tx_busy;
    while (bsy === 1'b1 && busy_clks < limit) begin
      busy_clks++;
      @(negedge clk);
      bsy = (d == 0) ? bus_a.tx_busy : bus_b.tx_busy;
    end
    if (busy_clks >= limit) check($sformatf("idle_timeout_%0d", d), busy_clks, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bc;
    int         fb;
    logic [8:0] w;
    bus_a.tx_data = '0; bus_a.tx_data_valid = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_data_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pin_a",   bus_a.tx_pin, 1);
    check("rst_busy_a",  bus_a.tx_busy, 0);
    check("rst_ready_a", bus_a.tx_data_ready, 0);
    check("rst_pin_b",   bus_b.tx_pin, 1);
    check("rst_ready_b", bus_b.tx_data_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst_a", bus_a.tx_data_ready, 1);
    check("ready_after_rst_b", bus_b.tx_data_ready, 1);

    // Single frame from idle
    drive(0, 9'h055, 1'b0);
    check("start_latency_a", bus_a.tx_pin, 0);
    wait_idle(0, 3000, bc);
    check("busy_len_55", bc, FRAME_A);

    // Parity cases: even on A, odd on B
    drive(0, 9'h007, 1'b0);
    wait_idle(0, 3000, bc);
    check("busy_len_07_a", bc, FRAME_A);
    drive(1, 9'h007, 1'b0);
    check("start_latency_b", bus_b.tx_pin, 0);
    wait_idle(1, 3000, bc);
    check("busy_len_07_b", bc, FRAME_B);

    // Back-to-back with valid held high
    start_q_a.delete();
    drive(0, 9'h0A5, 1'b1);
    drive(0, 9'h03C, 1'b0);
    check("ready_while_held", bus_a.tx_data_ready, 0);
    wait_idle(0, 3000, bc);
    check("busy_len_b2b", bc + 1, 2 * FRAME_A);
    check("b2b_frames", start_q_a.size(), 2);
    if (start_q_a.size() == 2) check("b2b_gap", start_q_a[1] - start_q_a[0], FRAME_A);

    // 7 data bits, 2 stop bits
    drive(1, 9'h07F, 1'b0);
    wait_idle(1, 3000, bc);
    check("busy_len_7f_b", bc, FRAME_B);

    // Reset in the middle of a frame with a word parked
    drive(0, 9'h03A, 1'b1);
    drive(0, 9'h0C3, 1'b0);
    repeat (33) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pin",   bus_a.tx_pin, 1);
    check("midrst_busy",  bus_a.tx_busy, 0);
    check("midrst_ready", bus_a.tx_data_ready, 0);
    check("midrst_held_pending", exp_q_a.size(), 1);
    exp_q_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", bus_a.tx_data_ready, 1);
    repeat (3 * CYCLE) @(negedge clk);
    check("idle_after_midrst_pin", bus_a.tx_pin, 1);
    check("idle_after_midrst_busy", bus_a.tx_busy, 0);
    drive(0, 9'h096, 1'b0);
    wait_idle(0, 3000, bc);
    check("busy_len_after_rst", bc, FRAME_A);

    // Randomly throttled stream of 50 words
    fb = frames[0];
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 3)) begin
        bus_a.tx_data_valid = 1'b0;
        bus_a.tx_data = 8'($urandom);
        @(negedge clk);
      end
      w = 9'($urandom_range(0, 255));
      drive(0, w, 1'($urandom_range(0, 1)));
    end
    bus_a.tx_data_valid = 1'b0;
    wait_idle(0, 60 * int'(FRAME_A), bc);
    check("rand_frames", frames[0] - fb, 50);
    check("sb_empty_a", exp_q_a.size(), 0);
    check("sb_empty_b", exp_q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
